// File: rtl/cordic_sched_pkg.sv
// Shared constants and width helpers for the CORDIC round-robin scheduler.
package cordic_sched_pkg;

  localparam int REQ_W_DEF   = 48;
  localparam int RSP_W_DEF   = 50;
  localparam int NREQ_DEF    = 4;
  localparam int MAX_OUT_DEF = 8;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Bits needed to name one requester (NREQ >= 2, so never zero).
  function automatic int tag_width(input int nreq);
    return clog2(nreq);
  endfunction

  // Occupancy counter must be able to hold MAX_OUT itself.
  function automatic int cnt_width(input int max_out);
    return clog2(max_out) + 1;
  endfunction

endpackage

// File: rtl/cordic_tag_fifo.sv
// Synchronous tag FIFO: remembers which requester issued each in-flight
// core operation. Head is read combinationally; push and pop may coincide,
// including push while full when a pop frees the slot in the same cycle.
module cordic_tag_fifo
  import cordic_sched_pkg::*;
#(
  parameter int DEPTH = MAX_OUT_DEF,
  parameter int WIDTH = 2,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_tag_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A pop only ever removes a real entry; a push into a full FIFO is only
  // legal when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Tag storage write port.
  always_ff @(posedge CLK) begin
    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one in-order CORDIC core between NREQ requesters: round-robin
// arbitration on the put side, tag FIFO to route each result back to the
// requester that issued it. Adds no latency in either direction.
module cordic_rr_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int  NREQ    = NREQ_DEF,
  parameter int  REQ_W   = REQ_W_DEF,
  parameter int  RSP_W   = RSP_W_DEF,
  parameter int  MAX_OUT = MAX_OUT_DEF,
  localparam int TAG_W   = tag_width(NREQ),
  localparam int CNT_W   = cnt_width(MAX_OUT)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*REQ_W-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [RSP_W-1:0]      rsp_data,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [REQ_W-1:0]      core_request_put,
  output logic                  core_EN_request_put,
  input  logic                  core_RDY_request_put,
  input  logic [RSP_W-1:0]      core_response_get,
  output logic                  core_EN_response_get,
  input  logic                  core_RDY_response_get,
  output logic [CNT_W-1:0]      outstanding
);

  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] grant_idx;
  logic             grant_any;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_full, fifo_empty;
  logic             issue, ret_avail, pop;

  // Round-robin grant: first valid requester at or after ptr, wrapping.
  // Scanning offsets from the far end lets the nearest match win last.
  always_comb begin
    logic [TAG_W-1:0] idx;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = TAG_W'((int'(ptr_q) + k) % NREQ);
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  // Return side: the head tag owns whatever the core is presenting.
  assign ret_avail = ~fifo_empty & core_RDY_response_get & ~RST;
  assign pop       = ret_avail & rsp_ready[head_tag];

  // A full FIFO may still accept a new tag when the head retires this cycle.
  assign issue = grant_any & core_RDY_request_put & (~fifo_full | pop) & ~RST;

  assign req_ready            = issue ? (NREQ'(1) << grant_idx) : '0;
  assign core_EN_request_put  = issue;
  assign core_request_put     = req_data[grant_idx*REQ_W +: REQ_W];

  assign rsp_valid            = ret_avail ? (NREQ'(1) << head_tag) : '0;
  assign rsp_data             = core_response_get;
  assign core_EN_response_get = pop;

  // Pointer moves just past the winner, only when something issues.
  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (grant_idx == TAG_W'(NREQ - 1)) ? '0 : grant_idx + TAG_W'(1);
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK) begin
    if (RST) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  cordic_tag_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (TAG_W)
  ) u_tag_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .push_i     (issue),
    .push_tag_i (grant_idx),
    .pop_i      (pop),
    .head_o     (head_tag),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (outstanding)
  );

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Directed bench for cordic_rr_scheduler with a small in-order core model.
module tb_cordic_rr_scheduler;

  localparam int NREQ    = 4;
  localparam int REQ_W   = 48;
  localparam int RSP_W   = 50;
  localparam int MAX_OUT = 8;
  localparam int CNT_W   = 4;

  localparam logic [REQ_W-1:0] T1_DATA = 48'h2000_0000_4000;  // z=0x2000 y=0 x=0x4000
  localparam logic [RSP_W-1:0] T1_RSP  = 50'h2_2000_0000_4000;

  logic                  CLK;
  logic                  RST;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*REQ_W-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [RSP_W-1:0]      rsp_data;
  logic [NREQ-1:0]       rsp_ready;
  logic [REQ_W-1:0]      core_request_put;
  logic                  core_EN_request_put;
  logic                  core_RDY_request_put;
  logic [RSP_W-1:0]      core_response_get;
  logic                  core_EN_response_get;
  logic                  core_RDY_response_get;
  logic [CNT_W-1:0]      outstanding;

  int n_checks;
  int n_fail;
  int cyc;
  int core_lat;
  bit core_ret_en;
  bit proto_err;

  typedef struct {
    logic [REQ_W-1:0] data;
    int               due;
  } op_t;
  op_t core_q[$];

  cordic_rr_scheduler #(
    .NREQ(NREQ), .REQ_W(REQ_W), .RSP_W(RSP_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .req_valid             (req_valid),
    .req_data              (req_data),
    .req_ready             (req_ready),
    .rsp_valid             (rsp_valid),
    .rsp_data              (rsp_data),
    .rsp_ready             (rsp_ready),
    .core_request_put      (core_request_put),
    .core_EN_request_put   (core_EN_request_put),
    .core_RDY_request_put  (core_RDY_request_put),
    .core_response_get     (core_response_get),
    .core_EN_response_get  (core_EN_response_get),
    .core_RDY_response_get (core_RDY_response_get),
    .outstanding           (outstanding)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Core presenting a result with nothing outstanding is a protocol error.
  always @(negedge CLK) begin
    if (!RST && core_RDY_response_get && outstanding == '0) proto_err = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [RSP_W-1:0] core_result(input logic [REQ_W-1:0] d);
    return {2'b10, d};
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive_core();
    core_RDY_response_get = core_ret_en && core_q.size() > 0 && core_q[0].due <= cyc;
    core_response_get     = (core_q.size() > 0) ? core_result(core_q[0].data) : '0;
  endtask

  task automatic settle();
    #1;
  endtask

  // Advance one clock: the core model consumes the handshakes seen before the edge.
  task automatic edge_step();
    bit               put_en, get_en, rst_s;
    logic [REQ_W-1:0] put_data;
    put_en   = core_EN_request_put;
    get_en   = core_EN_response_get;
    put_data = core_request_put;
    rst_s    = RST;
    @(posedge CLK);
    if (rst_s) begin
      core_q.delete();
    end else begin
      if (get_en && core_q.size() > 0) void'(core_q.pop_front());
      if (put_en) core_q.push_back('{data: put_data, due: cyc + core_lat});
    end
    cyc++;
    #1;
    drive_core();
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    req_valid = '0;
    settle();
    edge_step();
    RST = 1'b0;
    settle();
  endtask

  initial begin
    n_checks             = 0;
    n_fail               = 0;
    cyc                  = 0;
    core_lat             = 2;
    core_ret_en          = 1'b1;
    proto_err            = 1'b0;
    RST                  = 1'b1;
    req_valid            = '1;
    req_data             = '0;
    rsp_ready            = '1;
    core_RDY_request_put = 1'b1;
    drive_core();

    // Reset state, with every requester asking and the core ready.
    edge_step();
    settle();
    check("rst_req_ready", req_ready, 0);
    check("rst_en_put", core_EN_request_put, 0);
    check("rst_en_get", core_EN_response_get, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_outstanding", outstanding, 0);
    RST       = 1'b0;
    req_valid = '0;
    edge_step();
    settle();
    check("post_rst_outstanding", outstanding, 0);
    check("post_rst_rsp_valid", rsp_valid, 0);

    // Single requester 2, core latency 16.
    core_lat = 16;
    req_data[2*REQ_W +: REQ_W] = T1_DATA;
    req_valid = 4'b0100;
    settle();
    check("t1_req_ready", req_ready, 4'b0100);
    check("t1_en_put", core_EN_request_put, 1);
    check("t1_put_data", core_request_put, T1_DATA);
    edge_step();
    req_valid = '0;
    settle();
    check("t1_outstanding_1", outstanding, 1);
    for (int k = 1; k < 16; k++) begin
      check("t1_rsp_early", rsp_valid, 0);
      edge_step();
      settle();
    end
    check("t1_rsp_valid", rsp_valid, 4'b0100);
    check("t1_en_get", core_EN_response_get, 1);
    check("t1_rsp_data", rsp_data, T1_RSP);
    edge_step();
    settle();
    check("t1_outstanding_0", outstanding, 0);
    check("t1_rsp_gone", rsp_valid, 0);

    // All four valid, core always ready: grants rotate, tags return in order.
    do_reset();
    core_lat = 2;
    for (int i = 0; i < NREQ; i++) req_data[i*REQ_W +: REQ_W] = 48'h1111 * (i + 1);
    for (int i = 0; i < 10; i++) begin
      req_valid = (i < 8) ? 4'hF : 4'h0;
      settle();
      if (i < 8) check("t2_grant", req_ready, onehot(i % 4));
      if (i >= 2) begin
        check("t2_rsp_valid", rsp_valid, onehot((i - 2) % 4));
        check("t2_rsp_data", rsp_data, core_result(48'h1111 * ((i - 2) % 4 + 1)));
      end
      edge_step();
    end
    settle();
    check("t2_drained", outstanding, 0);

    // Fill: no returns, so exactly MAX_OUT issues, then the full-bypass issue.
    do_reset();
    core_ret_en = 1'b0;
    drive_core();
    req_valid = 4'hF;
    for (int i = 0; i < MAX_OUT; i++) begin
      settle();
      check("t3_fill_grant", req_ready, onehot(i % 4));
      edge_step();
    end
    settle();
    check("t3_full_ready", req_ready, 0);
    check("t3_full_count", outstanding, 8);
    core_ret_en = 1'b1;
    drive_core();
    settle();
    check("t3_bypass_rsp", rsp_valid, 4'b0001);
    check("t3_bypass_en_get", core_EN_response_get, 1);
    check("t3_bypass_grant", req_ready, 4'b0001);
    edge_step();
    settle();
    check("t3_bypass_count", outstanding, 8);
    check("t3_bypass_grant2", req_ready, 4'b0010);
    check("t3_bypass_rsp2", rsp_valid, 4'b0010);

    // Head-of-line: tag 1 stalled for 5 cycles blocks tag 3.
    do_reset();
    rsp_ready = 4'b1000;
    req_valid = 4'b0010;
    settle();
    check("t4_grant1", req_ready, 4'b0010);
    edge_step();
    req_valid = 4'b1000;
    settle();
    check("t4_grant3", req_ready, 4'b1000);
    edge_step();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("t4_hol_rsp", rsp_valid, 4'b0010);
      check("t4_hol_en", core_EN_response_get, 0);
      edge_step();
    end
    rsp_ready = 4'b1010;
    settle();
    check("t4_deliver1_en", core_EN_response_get, 1);
    check("t4_deliver1_data", rsp_data, core_result(48'h2222));
    edge_step();
    settle();
    check("t4_deliver3_rsp", rsp_valid, 4'b1000);
    check("t4_deliver3_en", core_EN_response_get, 1);
    edge_step();
    settle();
    check("t4_drained", outstanding, 0);
    rsp_ready = '1;

    // Reset with 5 outstanding clears FIFO and pointer.
    do_reset();
    core_ret_en = 1'b0;
    drive_core();
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) edge_step();
    req_valid = '0;
    settle();
    check("t5_before_rst", outstanding, 5);
    RST       = 1'b1;
    req_valid = 4'hF;
    settle();
    check("t5_rst_req_ready", req_ready, 0);
    check("t5_rst_en_put", core_EN_request_put, 0);
    edge_step();
    RST         = 1'b0;
    req_valid   = 4'b1001;
    core_ret_en = 1'b1;
    drive_core();
    settle();
    check("t5_outstanding", outstanding, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_ptr_zero_grant", req_ready, 4'b0001);
    edge_step();

    // Core not ready for 3 cycles: no grants, pointer holds.
    core_RDY_request_put = 1'b0;
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("t6_stall_ready", req_ready, 0);
      check("t6_stall_en", core_EN_request_put, 0);
      edge_step();
    end
    core_RDY_request_put = 1'b1;
    settle();
    check("t6_first_grant", req_ready, 4'b0010);
    edge_step();
    settle();
    check("t6_second_grant", req_ready, 4'b1000);
    edge_step();
    req_valid = '0;
    settle();

    check("protocol_error", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_rr_scheduler.md
# cordic_rr_scheduler

Shares one in-order CORDIC rotating core (48-bit request, 50-bit response, Bluespec-style put/get with RDY/EN) between NREQ requesters. Round-robin arbitration on the request side; a tag FIFO records the issuing requester of every outstanding operation so each response returns to its originator. Sits between the client front-ends and the core instance; drives the core's EN_request_put and EN_response_get directly.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- REQ_W, 48: core request width.
- RSP_W, 50: core response width.
- MAX_OUT, 8: maximum outstanding operations (tag FIFO depth, power of two).

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- req_valid  in  NREQ  requester i has a request.
- req_data  in  NREQ*REQ_W  request payload; slice i = bits [i*REQ_W +: REQ_W].
- req_ready  out  NREQ  request i accepted this cycle when req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ  response available for requester i.
- rsp_data  out  RSP_W  response payload, shared by all requesters; valid for the requester flagged in rsp_valid.
- rsp_ready  in  NREQ  requester i takes its response.
- core_request_put  out  REQ_W  payload to core.
- core_EN_request_put  out  1  core put enable.
- core_RDY_request_put  in  1  core can accept.
- core_response_get  in  RSP_W  core result.
- core_EN_response_get  out  1  core get enable.
- core_RDY_response_get  in  1  core result available.
- outstanding  out  clog2(MAX_OUT)+1  operations issued, not yet returned.

## Operation
- Arbiter: round-robin pointer ptr (reset 0). Grant = first i at or after ptr (wrapping) with req_valid[i]. Combinational in-cycle grant.
- Issue condition: any req_valid & core_RDY_request_put & (tag FIFO not full, or popping this cycle) & ~RST.
- On issue to g: req_ready[g]=1 (others 0), core_EN_request_put=1, core_request_put = slice g, push g into tag FIFO, ptr <= (g+1) mod NREQ. ptr unchanged when no issue.
- Return: head tag h valid when FIFO non-empty. rsp_valid[h] = core_RDY_response_get; rsp_data = core_response_get. core_EN_response_get = rsp_valid[h] & rsp_ready[h]; pop on that cycle.
- Non-head requesters' rsp_ready ignored; a stalled head blocks later returns (in-order core, head-of-line blocking is intended).
- core_RDY_response_get while FIFO empty: protocol error; no EN, sticky assertion in bench.
- outstanding = FIFO occupancy; +1 on push, -1 on pop, unchanged on both.

## Timing
- Reset values (during and first cycle after RST): req_ready=0, rsp_valid=0, core_EN_request_put=0, core_EN_response_get=0, outstanding=0, ptr=0, FIFO empty.
- Scheduler adds zero cycles: request reaches core in acceptance cycle; response delivered in the cycle core presents it and requester is ready. End-to-end latency = core latency.
- Full FIFO + pop in same cycle: issue permitted (occupancy stays MAX_OUT).
- Empty FIFO + push in same cycle: new tag not visible at head until next cycle (core cannot return in 0 cycles).
- RST mid-operation: FIFO and ptr cleared; core is reset by the same RST domain externally; in-flight results discarded.
- Outputs for req_ready/EN are combinational from inputs; no combinational path from rsp_ready to req_ready except via full-FIFO pop bypass.

## Structure
- Shared package cordic_sched_pkg: REQ_W/RSP_W defaults, tag width function clog2(NREQ), outstanding width.
- One sub-module: cordic_tag_fifo (synchronous FIFO, depth MAX_OUT, width clog2(NREQ), full/empty/count, simultaneous push/pop). Arbiter and return mux in top.
- Target 150-250 lines total.

## Test plan
- Single requester: req 2 issues x=0x4000,y=0,z=0x2000 with core latency 16 -> req_ready[2] in cycle of issue, rsp_valid[2] exactly 16 cycles later, outstanding 1 then 0.
- All four valid continuously, core always ready -> grants 0,1,2,3,0,1… one per cycle; responses return tagged 0,1,2,3 in order.
- Fill: core never returns, requesters always valid -> exactly 8 issues, then req_ready all 0, outstanding=8; enabling one return with concurrent request -> issue in same cycle, outstanding stays 8.
- Head-of-line: head tag 1 with rsp_ready[1]=0 for 5 cycles, rsp_ready[3]=1 -> no EN_response_get, rsp_valid only bit 1, for 5 cycles; then delivers 1 then 3.
- Reset with 5 outstanding -> next cycle outstanding=0, rsp_valid=0, ptr=0 (requester 0 wins next contention with 0 and 3).
- core_RDY_request_put=0 for 3 cycles with req_valid=4'b1010 -> no req_ready, ptr unchanged; then requester 1 granted first.
